// File: rtl/data_resp_pkg.sv
// Shared definitions for the data SRAM responder.
//   - config-window offsets (compared against addr[15:0])
//   - default physical base of the config window
//   - byte_merge(): lane-wise merge of a store into an existing word
package data_resp_pkg;

  localparam logic [31:0] DEFAULT_CONF_BASE = 32'h1faf_0000;

  localparam logic [15:0] CONF_LED_OFF   = 16'h0000;
  localparam logic [15:0] CONF_SW_OFF    = 16'h0004;
  localparam logic [15:0] CONF_SCR_OFF   = 16'h0008;
  localparam logic [15:0] CONF_TIMER_OFF = 16'he000;

  // Enabled lanes take the new byte, the rest keep the old one.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  wen);
    logic [31:0] w;
    w = old_w;
    for (int b = 0; b < 4; b++)
      if (wen[b]) w[8*b +: 8] = new_w[8*b +: 8];
    return w;
  endfunction

endpackage

// File: rtl/data_sram_resp_conf_regs.sv
// Config-register block of the data responder: LED, SWITCH (2-flop sync),
// SCRATCH and a free-running TIMER.
// Ports:
//   clk, rst          clock, async active-high reset
//   en_i              access to the config window this cycle
//   wen_i[3:0]        byte write enables (0 = read)
//   offset_i[15:0]    register offset within the window
//   wdata_i[31:0]     store data
//   rdata_next_o      word the top registers into rdata at the next edge
//   switch_i[7:0]     raw board switches (asynchronous)
//   led_o[15:0]       LED register
// Build option: DATA_RESP_WRITE_FIRST_EN makes a same-cycle read+write
// return the merged new value instead of the old one.
module conf_regs
  import data_resp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [3:0]  wen_i,
  input  logic [15:0] offset_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_next_o,
  input  logic [7:0]  switch_i,
  output logic [15:0] led_o
);

  logic [15:0] led_q, led_d;
  logic [7:0]  sw_meta_q, sw_sync_q;
  logic [31:0] scr_q, scr_d;
  logic [31:0] timer_q, timer_d;

  logic        wr;
  logic        hit_led, hit_sw, hit_scr, hit_timer;
  logic [31:0] led_merged, scr_merged, timer_merged;

  assign wr        = en_i && (wen_i != 4'b0000);
  assign hit_led   = (offset_i == CONF_LED_OFF);
  assign hit_sw    = (offset_i == CONF_SW_OFF);
  assign hit_scr   = (offset_i == CONF_SCR_OFF);
  assign hit_timer = (offset_i == CONF_TIMER_OFF);

  // LED keeps only lanes 0-1; upper half is forced to zero.
  assign led_merged   = byte_merge({16'h0, led_q}, wdata_i, {2'b00, wen_i[1:0]});
  assign scr_merged   = byte_merge(scr_q, wdata_i, wen_i);
  assign timer_merged = byte_merge(timer_q, wdata_i, wen_i);

  always_comb begin
    led_d   = led_q;
    scr_d   = scr_q;
    timer_d = timer_q + 32'd1;
    if (wr && hit_led)   led_d   = led_merged[15:0];
    if (wr && hit_scr)   scr_d   = scr_merged;
    // A store to TIMER wins over that cycle's increment.
    if (wr && hit_timer) timer_d = timer_merged;
  end

  always_comb begin
    rdata_next_o = 32'h0;
`ifdef DATA_RESP_WRITE_FIRST_EN
    if (hit_led)        rdata_next_o = wr ? led_merged : {16'h0, led_q};
    else if (hit_sw)    rdata_next_o = {24'h0, sw_sync_q};
    else if (hit_scr)   rdata_next_o = wr ? scr_merged : scr_q;
    else if (hit_timer) rdata_next_o = wr ? timer_merged : timer_q;
`else
    if (hit_led)        rdata_next_o = {16'h0, led_q};
    else if (hit_sw)    rdata_next_o = {24'h0, sw_sync_q};
    else if (hit_scr)   rdata_next_o = scr_q;
    else if (hit_timer) rdata_next_o = timer_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q     <= 16'h0;
      sw_meta_q <= 8'h0;
      sw_sync_q <= 8'h0;
      scr_q     <= 32'h0;
      timer_q   <= 32'h0;
    end else begin
      led_q     <= led_d;
      sw_meta_q <= switch_i;
      sw_sync_q <= sw_meta_q;
      scr_q     <= scr_d;
      timer_q   <= timer_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM responder: slave end of the core's en/wen/addr/wdata/rdata port.
// Holds a word-addressed RAM with byte-lane writes plus a config window
// (LED/SWITCH/SCRATCH/TIMER). Fixed one-cycle read latency, no backpressure.
// Ports:
//   clk, rst       clock, async active-high reset
//   en             access request
//   wen[3:0]       byte write enables (0 = read)
//   addr[31:0]     byte address (bits [1:0] ignored)
//   wdata[31:0]    store data
//   rdata[31:0]    read data, registered, holds when en is low
//   switch_i[7:0]  board switches
//   led_o[15:0]    LED register
// Build option: DATA_RESP_WRITE_FIRST_EN selects write-first read data on a
// same-cycle read+write; default is read-first.
module data_sram_resp
  import data_resp_pkg::*;
#(
  parameter int          RAM_AW    = 14,
  parameter logic [31:0] CONF_BASE = DEFAULT_CONF_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [7:0]  switch_i,
  output logic [15:0] led_o
);

  logic [31:0] mem [2**RAM_AW];

  logic              conf_sel;
  logic [RAM_AW-1:0] idx;
  logic              ram_we;
  logic [31:0]       ram_word;
  logic [31:0]       conf_rdata;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        unused_addr_lsb;

  assign unused_addr_lsb = addr[1:0];

  // Only the upper half is decoded; RAM address bits above RAM_AW alias.
  assign conf_sel = (addr[31:16] == CONF_BASE[31:16]);
  assign idx      = addr[RAM_AW+1:2];
  assign ram_we   = en && !conf_sel && (wen != 4'b0000);
  assign ram_word = mem[idx];

  conf_regs u_conf (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en && conf_sel),
    .wen_i        (wen),
    .offset_i     (addr[15:0]),
    .wdata_i      (wdata),
    .rdata_next_o (conf_rdata),
    .switch_i     (switch_i),
    .led_o        (led_o)
  );

  always_ff @(posedge clk) begin
    if (ram_we)
      for (int b = 0; b < 4; b++)
        if (wen[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
  end

  always_comb begin
    rdata_d = rdata_q;
    if (en) begin
      if (conf_sel)
        rdata_d = conf_rdata;
      else
`ifdef DATA_RESP_WRITE_FIRST_EN
        rdata_d = byte_merge(ram_word, wdata, wen);
`else
        rdata_d = ram_word;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= 32'h0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_data_sram_resp.sv
module tb_data_sram_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  switch_i;
  logic [15:0] led_o;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] CB = 32'h1faf_0000;

  data_sram_resp dut (
    .clk(clk), .rst(rst), .en(en), .wen(wen), .addr(addr), .wdata(wdata),
    .rdata(rdata), .switch_i(switch_i), .led_o(led_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access presented for one edge, then the bus goes idle.
  task automatic acc(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    en = 1'b1; addr = a; wen = w; wdata = d;
    tick;
    en = 1'b0; wen = 4'h0;
  endtask

  initial begin
    logic [31:0] same_exp;
    rst = 1'b1; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0; switch_i = 8'h00;
    tick; tick;
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_led", {16'h0, led_o}, 32'h0);
    rst = 1'b0;
    tick;

    // RAM full-word write then read
    acc(32'h0000_0100, 4'hf, 32'hdead_beef);
    acc(32'h0000_0100, 4'h0, 32'h0);
    chk("ram_rd_full", rdata, 32'hdead_beef);
    tick;
    chk("rdata_hold", rdata, 32'hdead_beef);

    // Byte-lane write
    acc(32'h0000_0200, 4'hf, 32'haaaa_aaaa);
    acc(32'h0000_0200, 4'b0101, 32'h1122_3344);
    acc(32'h0000_0200, 4'h0, 32'h0);
    chk("ram_byte_lane", rdata, 32'haa22_aa44);

    // High address bits alias into the RAM
    acc(32'h0001_0100, 4'hf, 32'hcafe_0001);
    acc(32'h0000_0100, 4'h0, 32'h0);
    chk("ram_alias", rdata, 32'hcafe_0001);

    // Same-cycle read+write
    acc(32'h0000_0300, 4'hf, 32'h0);
`ifdef DATA_RESP_WRITE_FIRST_EN
    same_exp = 32'h5555_5555;
`else
    same_exp = 32'h0;
`endif
    acc(32'h0000_0300, 4'hf, 32'h5555_5555);
    chk("ram_same_cycle", rdata, same_exp);
    acc(32'h0000_0300, 4'h0, 32'h0);
    chk("ram_after_rw", rdata, 32'h5555_5555);

    // TIMER: write, then back-to-back reads (each returns the pre-edge value)
    acc(CB | 32'he000, 4'hf, 32'hffff_fffe);
    en = 1'b1; addr = CB | 32'he000; wen = 4'h0;
    tick;
    chk("timer_loaded", rdata, 32'hffff_fffe);
    tick;
    chk("timer_inc", rdata, 32'hffff_ffff);
    tick;
    chk("timer_wrap", rdata, 32'h0000_0000);
    en = 1'b0;

    // LED write, readback, unmapped offset
    acc(CB | 32'h0000, 4'hf, 32'h0001_abcd);
    chk("led_o", {16'h0, led_o}, 32'h0000_abcd);
    acc(CB | 32'h0000, 4'h0, 32'h0);
    chk("led_rd", rdata, 32'h0000_abcd);
    acc(CB | 32'h0010, 4'hf, 32'h1234_5678);
    acc(CB | 32'h0010, 4'h0, 32'h0);
    chk("unmapped_rd", rdata, 32'h0);

    // SCRATCH byte lanes
    acc(CB | 32'h0008, 4'hf, 32'hffff_ffff);
    acc(CB | 32'h0008, 4'b0010, 32'h1234_5678);
    acc(CB | 32'h0008, 4'h0, 32'h0);
    chk("scratch_lane", rdata, 32'hffff_56ff);

    // SWITCH synchroniser
    switch_i = 8'h5a;
    tick; tick;
    acc(CB | 32'h0004, 4'h0, 32'h0);
    chk("switch_rd", rdata, 32'h0000_005a);

    // Async reset mid-stream
    en = 1'b1; addr = CB | 32'h0000; wen = 4'h0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_led", {16'h0, led_o}, 32'h0);
    en = 1'b0;
    tick;
    @(negedge clk);
    rst = 1'b0;
    acc(CB | 32'he000, 4'h0, 32'h0);
    chk("rst_timer", rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
